// File: rtl/stochastic_adder.sv
`default_nettype none
// ============================================================================
// Module      : stochastic_adder
// Description : Scaled stochastic-computing adder for unipolar bitstreams.
//               y multiplexes a or b under a select bit, so P(y) equals
//               (P(a)+P(b))/2 for a 0.5-probability select. A clocked back
//               end counts the ones in y over each BIT_LENGTH-bit stream and
//               reports the count.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               a, b            - operand bitstream bits
//               rand_bit        - external select bit
//               sel_mode        - 0: select = rand_bit, 1: select = lfsr[0]
//               en              - consume the current bit on this edge
//               clear           - abort the stream, zero the accumulation
//               y               - combinational sum bit
//               ones_count      - ones in y over the last completed stream
//               done            - one-cycle pulse when ones_count updates
//               bit_idx         - index of the next bit within the stream
// Revision    : 1.0 - initial release
// ============================================================================
module stochastic_adder #(
  parameter int          BIT_LENGTH = 128,
  parameter int          CNT_W      = $clog2(BIT_LENGTH + 1),
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             rand_bit,
  input  logic             sel_mode,
  input  logic             en,
  input  logic             clear,
  output logic             y,
  output logic [CNT_W-1:0] ones_count,
  output logic             done,
  output logic [CNT_W-1:0] bit_idx
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0]      SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BIT_LENGTH - 1);

  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             done_q, done_d;

  logic             sel;
  logic             lfsr_fb;
  logic [CNT_W-1:0] y_ext;

  // Select and sum bit: purely combinational, independent of clk/en/rst.
  always_comb begin
    sel = sel_mode ? lfsr_q[0] : rand_bit;
    y   = sel ? a : b;
  end

  always_comb begin
    // Taps x^16 + x^14 + x^13 + x^11 + 1 map to bits 15, 13, 12, 10.
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    y_ext   = {{(CNT_W-1){1'b0}}, y};

    lfsr_d = lfsr_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    ones_d = ones_q;
    done_d = 1'b0;

    // The LFSR advances with every consumed bit, clear or not.
    if (en) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end

    if (clear) begin
      // clear dominates a coincident last bit: no count, no pulse.
      acc_d = '0;
      idx_d = '0;
    end else if (en) begin
      if (idx_q == LAST_IDX) begin
        // acc holds at most BIT_LENGTH-1 here, so the sum fits CNT_W.
        ones_d = acc_q + y_ext;
        done_d = 1'b1;
        acc_d  = '0;
        idx_d  = '0;
      end else begin
        acc_d = acc_q + y_ext;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_EFF;
      acc_q  <= '0;
      idx_q  <= '0;
      ones_q <= '0;
      done_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      ones_q <= ones_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    ones_count = ones_q;
    done       = done_q;
    bit_idx    = idx_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_stochastic_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_stochastic_adder
// Description : Self-checking bench for stochastic_adder. A stream-level
//               model (queue of consumed y bits, software LFSR) predicts
//               the outputs; a negedge process compares every cycle, and
//               directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stochastic_adder;

  localparam int BL    = 128;
  localparam int CNT_W = $clog2(BL + 1);

  logic             clk = 1'b0;
  logic             rst, a, b, rand_bit, sel_mode, en, clear;
  logic             y, done;
  logic [CNT_W-1:0] ones_count, bit_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stochastic_adder #(.BIT_LENGTH(BL), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .rand_bit(rand_bit), .sel_mode(sel_mode),
    .en(en), .clear(clear), .y(y), .ones_count(ones_count), .done(done), .bit_idx(bit_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Galois-free software LFSR step: feedback is the parity of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s << 1) | 16'(^(s & 16'hB400));
  endfunction

  // ---------------- stream-level model ----------------
  bit          q[$];
  int          m_ones = 0;
  bit          m_done = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ones = 0;
      m_done = 0;
      m_lfsr = 16'hACE1;
      chk_en = 1;
    end else begin
      bit yb;
      yb     = ((sel_mode ? m_lfsr[0] : rand_bit) ? a : b);
      m_done = 0;
      if (clear) begin
        q.delete();
      end else if (en) begin
        q.push_back(yb);
        if (q.size() == BL) begin
          int s;
          s = 0;
          foreach (q[i]) s += int'(q[i]);
          m_ones = s;
          m_done = 1;
          q.delete();
        end
      end
      if (en) m_lfsr = lfsr_next(m_lfsr);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("y_model", 32'(y), 32'((sel_mode ? m_lfsr[0] : rand_bit) ? a : b));
      chk("done_model", 32'(done), 32'(m_done));
      chk("ones_model", 32'(ones_count), 32'(m_ones));
      chk("idx_model", 32'(bit_idx), 32'(q.size()));
    end
  end

  task automatic step(input logic ai, bi, ri, si, ei, ci, rsti);
    a = ai; b = bi; rand_bit = ri; sel_mode = si; en = ei; clear = ci; rst = rsti;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int done_at[$];
    int lones;
    logic [15:0] sw;
    a = 0; b = 0; rand_bit = 0; sel_mode = 0; en = 0; clear = 0; rst = 1;

    // Reset
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("reset_ones", 32'(ones_count), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_idx", 32'(bit_idx), 0);
    rst = 0;

    // Combinational mux, en low so no state changes
    for (int i = 0; i < 8; i++) begin
      a = i[2]; b = i[1]; rand_bit = i[0]; sel_mode = 0; en = 0;
      #1;
      chk("comb_mux", 32'(y), 32'(i[0] ? i[2] : i[1]));
    end

    // Half scaling: a=1, b=0, select alternating 1,0
    for (int i = 0; i < BL; i++) step(1, 0, (i % 2) == 0, 0, 1, 0, 0);
    chk("half_done", 32'(done), 1);
    chk("half_ones", 32'(ones_count), 64);

    // Maximum without wrap
    for (int i = 0; i < BL; i++) step(1, 1, $urandom_range(0, 1), 0, 1, 0, 0);
    chk("max_ones", 32'(ones_count), 128);

    // Gapped en: bits on odd cycles only
    for (int i = 0; i < 2 * BL; i++) begin
      step(1, 0, ((i / 2) % 2) == 0, 0, (i % 2) == 1, 0, 0);
      if (i == 2) chk("gap_idx_hold", 32'(bit_idx), 1);
    end
    chk("gap_done", 32'(done), 1);
    chk("gap_ones", 32'(ones_count), 64);

    // Mid-stream reset at bit 50, then a full a=b=1 stream
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("rst_idx", 32'(bit_idx), 0);
    for (int i = 0; i < BL - 1; i++) step(1, 1, 0, 0, 1, 0, 0);
    chk("rst_no_early_done", 32'(done), 0);
    step(1, 1, 0, 0, 1, 0, 0);
    chk("rst_done", 32'(done), 1);
    chk("rst_ones", 32'(ones_count), 128);

    // clear coincident with the last bit
    for (int i = 0; i < BL - 1; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("clear_no_done", 32'(done), 0);
    chk("clear_hold_ones", 32'(ones_count), 128);
    chk("clear_idx", 32'(bit_idx), 0);

    // LFSR mode from seed ACE1
    step(0, 0, 0, 0, 0, 0, 1);
    sw = 16'hACE1;
    lones = 0;
    for (int i = 0; i < BL; i++) begin
      a = 1; b = 0; rand_bit = 0; sel_mode = 1; en = 1; clear = 0; rst = 0;
      #1;
      if (i < 2) chk("lfsr_first_bits", 32'(y), 1);
      chk("lfsr_seq", 32'(y), 32'(sw[0]));
      lones += int'(sw[0]);
      sw = lfsr_next(sw);
      @(posedge clk);
      #1;
    end
    chk("lfsr_ones", 32'(ones_count), 32'(lones));
    chk("lfsr_range", 32'((lones >= 48) && (lones <= 80)), 1);

    // Randomized phase
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);

    // Back-to-back streams
    step(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 3 * BL; k++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, 1, 0, 0);
      if (done) done_at.push_back(k);
    end
    chk("b2b_count", 32'(done_at.size()), 3);
    for (int i = 0; i < 3; i++)
      chk("b2b_time", (i < done_at.size()) ? 32'(done_at[i]) : 32'hFFFF_FFFF, 32'(BL * (i + 1)));

    step(0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
